flag_branch_unit: RTL
=====================

Name: flag_branch_unit

Overview:
- Consumer end of the ALU flag interface: holds the architectural ZNCV status register, written from the ALU's 4-bit zncv output (bit3 Z, bit2 N, bit1 C, bit0 V).
- Resolves conditional branches against those flags and issues a registered PC redirect to the fetch stage.
- Sits between the ALU and the PC/fetch logic of the 8-bit core.

Parameters:
- PC_W, 8, program counter / branch target width in bits.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset; synchronous, active-low.
- flag_we_i  input  1  write enable for the status register this cycle.
- zncv_i  input  4  flags from the ALU: [3]Z [2]N [1]C [0]V.
- br_valid_i  input  1  branch request valid.
- br_ready_o  output  1  unit can accept a branch this cycle.
- br_cond_i  input  4  condition code (encoding below).
- br_target_i  input  PC_W  taken target.
- pc_i  input  PC_W  PC of the branch instruction.
- resolve_o  output  1  one-cycle pulse: a branch resolved.
- taken_o  output  1  resolved branch was taken; valid only with resolve_o.
- redirect_pc_o  output  PC_W  next PC: target if taken, else pc_i+1 mod 2^PC_W; valid only with resolve_o.
- flags_o  output  4  current status register.

Behaviour:
- Reset (rst_ni low at an edge) values: flags_o=0, resolve_o=0, taken_o=0, redirect_pc_o=0, br_ready_o=1, FSM=IDLE. Reset mid-stall drops the pending branch; no resolve is issued.
- Status register: on an edge with flag_we_i=1, flags_o <= zncv_i. Otherwise flags_o holds.
- Condition codes:
  - 0 AL (1)
  - 1 EQ Z
  - 2 NE !Z
  - 3 CS C
  - 4 CC !C
  - 5 MI N
  - 6 PL !N
  - 7 VS V
  - 8 VC !V
  - 9 HI C&!Z
  - 10 LS !C|Z
  - 11 GE N==V
  - 12 LT N!=V
  - 13 GT !Z&(N==V)
  - 14 LE Z|(N!=V)
  - 15 NV (0)
- Handshake:
  - A branch is accepted on an edge where br_valid_i & br_ready_o.
  - br_cond_i, br_target_i and pc_i are sampled only at acceptance; the unit registers them internally.
- Latency: resolve_o pulses exactly 1 cycle after the evaluation edge. taken_o and redirect_pc_o are registered alongside it. When resolve_o=0, taken_o=0 and redirect_pc_o holds its last value.
- FSM states:
  - IDLE: br_ready_o=1.
    - Accept with no hazard: evaluate against flags_o, go to RESOLVE.
    - Accept with hazard (flag_we_i=1 in the same cycle, forwarding compiled out): go to STALL.
  - STALL: br_ready_o=0. Next edge evaluates the captured branch against the now-updated flags_o, go to RESOLVE.
  - RESOLVE: resolve_o=1, br_ready_o=1. A back-to-back accept follows the IDLE rules; otherwise go to IDLE.
- A flag write during STALL is applied to the register, but evaluation uses flags_o as it stood at the start of that STALL cycle (the write that caused the stall).
- pc_i+1 wraps: PC_W=8, pc_i=0xFF gives 0x00.
- Conditions AL and NV are evaluated normally, with no special path. A hazard on them still stalls when forwarding is compiled out.

Optional Feature:
- Macro: FLAG_BRANCH_FWD_EN.
- Defined: a branch accepted in the same cycle as flag_we_i=1 is evaluated against zncv_i (forwarded). It never stalls; the STALL state is unreachable and br_ready_o stays 1 outside reset.
- Undefined: the STALL path described above applies; the hazard costs one extra cycle.

Decomposition:
- Shared package core_pkg:
  - Condition-code localparams COND_AL..COND_NV.
  - Flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0, shared with the ALU.
  - FSM state encoding (2-bit: IDLE, STALL, RESOLVE).
- Sub-module: cond_eval, purely combinational (flags[3:0], cond[3:0] -> take). It is reusable for predicated execution later.

Test Plan:
- Reset: hold rst_ni=0 two edges with flag_we_i=1, zncv_i=4'hF -> flags_o=0, br_ready_o=1, resolve_o=0.
- Write zncv_i=4'b1000 (Z), then branch EQ with target=0x40, pc=0x10 -> next cycle resolve_o=1, taken_o=1, redirect_pc_o=0x40. Repeat with NE -> taken_o=0, redirect_pc_o=0x11.
- Signed conditions: flags N=1, V=0 -> LT taken, GE not taken, GT not taken, LE taken. Flags N=1, V=1, Z=0 -> GT taken.
- Wrap-around: pc_i=0xFF, cond NV -> redirect_pc_o=0x00, taken_o=0.
- Hazard: flags=0, then in the same cycle flag_we_i=1, zncv_i=Z and branch EQ.
  - Without macro: br_ready_o=0 for one cycle, resolve two cycles after accept, taken_o=1.
  - With macro: resolve one cycle after accept, taken_o=1.
- Back-to-back branches on consecutive cycles (no hazard) -> resolve_o high two consecutive cycles with correct per-branch results. Reset asserted during STALL -> no resolve_o pulse follows.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit core: branch condition codes, ZNCV flag bit
// positions (common with the ALU) and the branch unit state encoding.
package core_pkg;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_CS = 4'd3;
    localparam logic [3:0] COND_CC = 4'd4;
    localparam logic [3:0] COND_MI = 4'd5;
    localparam logic [3:0] COND_PL = 4'd6;
    localparam logic [3:0] COND_VS = 4'd7;
    localparam logic [3:0] COND_VC = 4'd8;
    localparam logic [3:0] COND_HI = 4'd9;
    localparam logic [3:0] COND_LS = 4'd10;
    localparam logic [3:0] COND_GE = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GT = 4'd13;
    localparam logic [3:0] COND_LE = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StStall   = 2'd1,
        StResolve = 2'd2
    } br_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: decides whether a condition holds for
// a given ZNCV flag set. Kept standalone so predicated execution can reuse it.
module cond_eval
    import core_pkg::*;
(
    input  logic [3:0] flags_i,
    input  logic [3:0] cond_i,
    output logic       take_o
);

    logic z, n, c, v;

    assign z = flags_i[FLAG_Z];
    assign n = flags_i[FLAG_N];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    always_comb begin
        take_o = 1'b0;
        unique case (cond_i)
            COND_AL: take_o = 1'b1;
            COND_EQ: take_o = z;
            COND_NE: take_o = ~z;
            COND_CS: take_o = c;
            COND_CC: take_o = ~c;
            COND_MI: take_o = n;
            COND_PL: take_o = ~n;
            COND_VS: take_o = v;
            COND_VC: take_o = ~v;
            COND_HI: take_o = c & ~z;
            COND_LS: take_o = ~c | z;
            COND_GE: take_o = (n == v);
            COND_LT: take_o = (n != v);
            COND_GT: take_o = ~z & (n == v);
            COND_LE: take_o = z | (n != v);
            COND_NV: take_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// ZNCV status register plus conditional branch resolver issuing a registered PC redirect.
// Define FLAG_BRANCH_FWD_EN to forward same-cycle flag writes instead of stalling.
module flag_branch_unit
    import core_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flag_we_i,
    input  logic [3:0]      zncv_i,
    input  logic            br_valid_i,
    output logic            br_ready_o,
    input  logic [3:0]      br_cond_i,
    input  logic [PC_W-1:0] br_target_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            resolve_o,
    output logic            taken_o,
    output logic [PC_W-1:0] redirect_pc_o,
    output logic [3:0]      flags_o
);

    br_state_e       state_q, state_d;
    logic [3:0]      flags_q;
    logic [3:0]      cond_q;
    logic [PC_W-1:0] target_q, pc_q;
    logic            taken_q, taken_d;
    logic [PC_W-1:0] redirect_q, redirect_d;

    logic            accept, hazard, in_stall, eval_now, eval_take;
    logic [3:0]      fwd_flags, eval_flags, eval_cond;
    logic [PC_W-1:0] eval_target, eval_pc;

    assign accept   = br_valid_i & br_ready_o;
    assign in_stall = (state_q == StStall);

`ifdef FLAG_BRANCH_FWD_EN
    assign hazard    = 1'b0;
    assign fwd_flags = flag_we_i ? zncv_i : flags_q;
`else
    assign hazard    = flag_we_i;
    assign fwd_flags = flags_q;
`endif

    // A stalled branch evaluates against the flags latched by the write that stalled it.
    assign eval_now    = in_stall | (accept & ~hazard);
    assign eval_flags  = in_stall ? flags_q  : fwd_flags;
    assign eval_cond   = in_stall ? cond_q   : br_cond_i;
    assign eval_target = in_stall ? target_q : br_target_i;
    assign eval_pc     = in_stall ? pc_q     : pc_i;

    cond_eval u_cond_eval (
        .flags_i (eval_flags),
        .cond_i  (eval_cond),
        .take_o  (eval_take)
    );

    assign taken_d    = eval_now & eval_take;
    assign redirect_d = !eval_now ? redirect_q :
                        eval_take ? eval_target : eval_pc + PC_W'(1);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StResolve: begin
                if (accept) begin
                    state_d = hazard ? StStall : StResolve;
                end else begin
                    state_d = StIdle;
                end
            end
            StStall: state_d = StResolve;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        br_ready_o = (state_q != StStall);
        resolve_o  = (state_q == StResolve);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            flags_q    <= 4'h0;
            cond_q     <= COND_AL;
            target_q   <= '0;
            pc_q       <= '0;
            taken_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            if (flag_we_i) begin
                flags_q <= zncv_i;
            end
            if (accept) begin
                cond_q   <= br_cond_i;
                target_q <= br_target_i;
                pc_q     <= pc_i;
            end
            taken_q    <= taken_d;
            redirect_q <= redirect_d;
        end
    end

    assign taken_o       = taken_q;
    assign redirect_pc_o = redirect_q;
    assign flags_o       = flags_q;

endmodule
